// File: rtl/i2c_slave_core_if.sv
// Bus and local-side signals of the I2C target core.
// Handshake: rx_valid_o and tx_req_o are single-cycle strobes with no ready.
// rx_data_o holds its value until the next rx_valid_o. tx_data_i must be
// stable in the cycle before tx_req_o is high; it is captured on the clock
// edge that raises tx_req_o. dbg_state: 0 idle, 1 addr, 2 addr_ack, 3 rx,
// 4 rx_ack, 5 tx, 6 tx_ack.
interface i2c_slave_core_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i;
    logic       tx_req_o;
    logic       busy_o;
    logic       rw_o;
    logic [2:0] dbg_state;

    modport slave (
        input  scl_i, sda_i, tx_data_i,
        output sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, rw_o, dbg_state
    );

    modport master (
        output scl_i, sda_i, tx_data_i,
        input  sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, rw_o, dbg_state
    );
endinterface

// File: rtl/i2c_slave_core.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive with strobe and byte transmit from local logic; no stretching.
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             i2c_core_clock_i,
    input  logic             core_reset_i,
    i2c_slave_core_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX       = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX       = 3'd5,
        S_TX_ACK   = 3'd6
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_q, sda_q;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    logic       sda_oe, sda_oe_d;
    logic [7:0] rx_data, rx_data_d;
    logic       rx_valid, rx_valid_d;
    logic       tx_req, tx_req_d;
    logic       busy, busy_d;
    logic       rw, rw_d;
    logic [7:0] shreg, shreg_d;
    logic [2:0] cnt, cnt_d;
    logic       byte_full, byte_full_d;

    // Idle-high reset of the synchronisers keeps a released bus from looking like an edge.
    always_ff @(posedge i2c_core_clock_i) begin
        if (core_reset_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start_ev = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_ev  = scl_s & scl_q & ~sda_q & sda_s;

    always_ff @(posedge i2c_core_clock_i) begin
        if (core_reset_i) state <= S_IDLE;
        else              state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (start_ev) begin
            state_d = S_ADDR;
        end else if (stop_ev) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_ADDR:     if (scl_fall && byte_full)
                                state_d = (shreg[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK: if (scl_fall) state_d = rw ? S_TX : S_RX;
                S_RX:       if (scl_fall && byte_full) state_d = S_RX_ACK;
                S_RX_ACK:   if (scl_fall) state_d = S_RX;
                S_TX:       if (scl_fall && cnt == 3'd7) state_d = S_TX_ACK;
                S_TX_ACK: begin
                    if (scl_rise && sda_s) state_d = S_IDLE;
                    else if (scl_fall)     state_d = S_TX;
                end
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Next values of every registered output and of the byte datapath.
    always_comb begin
        sda_oe_d    = sda_oe;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        busy_d      = busy;
        rw_d        = rw;
        shreg_d     = shreg;
        cnt_d       = cnt;
        byte_full_d = byte_full;
        if (start_ev || stop_ev) begin
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = 3'd0;
            byte_full_d = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_RX: begin
                    if (scl_rise) begin
                        shreg_d = {shreg[6:0], sda_s};
                        cnt_d   = cnt + 3'd1;
                        if (cnt == 3'd7) byte_full_d = 1'b1;
                    end else if (scl_fall && byte_full) begin
                        byte_full_d = 1'b0;
                        if (state == S_RX) begin
                            rx_data_d  = shreg;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                        end else if (shreg[7:1] == SLAVE_ADDR) begin
                            sda_oe_d = 1'b1;
                            rw_d     = shreg[0];
                            busy_d   = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    cnt_d    = 3'd0;
                end
                S_TX: if (scl_fall) begin
                    // Bit 7 went out on entry; each fall presents the next bit down.
                    cnt_d    = cnt + 3'd1;
                    sda_oe_d = (cnt == 3'd7) ? 1'b0 : ~shreg[6];
                    shreg_d  = {shreg[6:0], 1'b0};
                end
                default: ;
            endcase
            if ((state == S_ADDR_ACK && scl_fall && !rw) ) begin
                sda_oe_d = 1'b0;
                cnt_d    = 3'd0;
            end
            if (state == S_TX_ACK && scl_rise && sda_s) begin
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
            if ((state == S_ADDR_ACK && scl_fall && rw) || (state == S_TX_ACK && scl_fall)) begin
                tx_req_d = 1'b1;
                shreg_d  = bus.tx_data_i;
                sda_oe_d = ~bus.tx_data_i[7];
                cnt_d    = 3'd0;
            end
        end
    end

    always_ff @(posedge i2c_core_clock_i) begin
        if (core_reset_i) begin
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            shreg     <= 8'h00;
            cnt       <= 3'd0;
            byte_full <= 1'b0;
        end else begin
            sda_oe    <= sda_oe_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            tx_req    <= tx_req_d;
            busy      <= busy_d;
            rw        <= rw_d;
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            byte_full <= byte_full_d;
        end
    end

    assign bus.sda_oe_o   = sda_oe;
    assign bus.rx_data_o  = rx_data;
    assign bus.rx_valid_o = rx_valid;
    assign bus.tx_req_o   = tx_req;
    assign bus.busy_o     = busy;
    assign bus.rw_o       = rw;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bus-level master model drives frames,
// a transaction-level model predicts received bytes and strobes.
module tb_i2c_slave_core;
    localparam int          Q       = 8;       // core cycles per quarter SCL period
    localparam logic [6:0]  ADDR    = 7'h55;
    localparam logic [2:0]  ST_IDLE = 3'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_slave_core_if bus ();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe_o;   // open-drain wired-AND

    i2c_slave_core #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .i2c_core_clock_i (clk),
        .core_reset_i     (rst),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         rx_seen = 0;
    int         tx_seen = 0;
    logic       quiet = 1'b0;
    logic       prev_rx = 1'b0;
    logic       prev_tx = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte is acknowledged and delivered only when its frame addressed us for write.
    function automatic logic addr_hits(input logic [7:0] a);
        return a[7:1] == ADDR;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_rx = 1'b0;
            prev_tx = 1'b0;
        end else begin
            if (bus.rx_valid_o || bus.tx_req_o)
                check("pulse_overlap", {31'd0, bus.rx_valid_o & bus.tx_req_o}, 32'd0);
            if (bus.rx_valid_o) begin
                rx_seen++;
                check("rx_valid_width", {31'd0, prev_rx}, 32'd0);
                if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else                   check("rx_data", {24'd0, bus.rx_data_o}, {24'd0, exp_q.pop_front()});
            end
            if (bus.tx_req_o) begin
                tx_seen++;
                check("tx_req_width", {31'd0, prev_tx}, 32'd0);
            end
            if (quiet) check("oe_quiet", {31'd0, bus.sda_oe_o}, 32'd0);
            prev_rx = bus.rx_valid_o;
            prev_tx = bus.tx_req_o;
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        r = bus.sda_i; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(~master_ack, r);
    endtask

    // Data byte of a write frame; model queues it when the frame was ours.
    task automatic host_write(input logic [7:0] d, input logic ours, input string name);
        logic ack;
        if (ours) exp_q.push_back(d);
        send_byte(d, ack);
        check(name, {31'd0, ack}, {31'd0, ours});
    endtask

    logic       ack, r;
    logic [7:0] d;
    int         tx0, rx0;

    initial begin
        bus.tx_data_i = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_oe",    {31'd0, bus.sda_oe_o},   32'd0);
        check("rst_rxd",   {24'd0, bus.rx_data_o},  32'd0);
        check("rst_flags", {29'd0, bus.rx_valid_o, bus.tx_req_o, bus.busy_o}, 32'd0);
        check("rst_rw",    {31'd0, bus.rw_o},       32'd0);
        check("rst_state", {29'd0, bus.dbg_state},  {29'd0, ST_IDLE});
        rst = 1'b0;
        wait_q();

        // 1: write one byte
        i2c_start();
        send_byte(8'hAA, ack);
        check("t1_addr_ack", {31'd0, ack}, {31'd0, addr_hits(8'hAA)});
        check("t1_busy", {31'd0, bus.busy_o}, 32'd1);
        check("t1_rw",   {31'd0, bus.rw_o},   32'd0);
        host_write(8'hAA, 1'b1, "t1_data_ack");
        i2c_stop();
        wait_q();
        check("t1_busy_end", {31'd0, bus.busy_o}, 32'd0);
        check("t1_state",    {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
        check("t1_rx_count", rx_seen, 1);

        // 2: address mismatch, slave must never drive
        quiet = 1'b1;
        i2c_start();
        send_byte(8'hA8, ack);
        check("t2_addr_nack", {31'd0, ack}, {31'd0, addr_hits(8'hA8)});
        check("t2_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
        host_write(8'h12, 1'b0, "t2_data_nack");
        i2c_stop();
        wait_q();
        quiet = 1'b0;
        check("t2_rx_count", rx_seen, 1);
        check("t2_busy", {31'd0, bus.busy_o}, 32'd0);

        // 3: read two bytes, ACK then NACK
        tx0 = tx_seen;
        bus.tx_data_i = 8'h3C;
        i2c_start();
        send_byte(8'hAB, ack);
        check("t3_addr_ack", {31'd0, ack}, 32'd1);
        check("t3_rw",   {31'd0, bus.rw_o},   32'd1);
        check("t3_busy", {31'd0, bus.busy_o}, 32'd1);
        bus.tx_data_i = 8'hF0;
        recv_byte(1'b1, d);
        check("t3_byte1", {24'd0, d}, 32'h3C);
        recv_byte(1'b0, d);
        check("t3_byte2", {24'd0, d}, 32'hF0);
        check("t3_state_nack", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
        check("t3_busy_nack",  {31'd0, bus.busy_o}, 32'd0);
        i2c_stop();
        wait_q();
        check("t3_tx_count", tx_seen - tx0, 2);
        check("t3_oe", {31'd0, bus.sda_oe_o}, 32'd0);

        // 4: write, repeated START, read
        tx0 = tx_seen;
        i2c_start();
        send_byte(8'hAA, ack);
        check("t4_waddr_ack", {31'd0, ack}, 32'd1);
        host_write(8'h12, 1'b1, "t4_data_ack");
        check("t4_rw_w", {31'd0, bus.rw_o}, 32'd0);
        bus.tx_data_i = 8'h77;
        i2c_rstart();
        send_byte(8'hAB, ack);
        check("t4_raddr_ack", {31'd0, ack}, 32'd1);
        check("t4_rw_r", {31'd0, bus.rw_o}, 32'd1);
        recv_byte(1'b0, d);
        check("t4_rbyte", {24'd0, d}, 32'h77);
        i2c_stop();
        wait_q();
        check("t4_rx_data",  {24'd0, bus.rx_data_o}, 32'h12);
        check("t4_tx_count", tx_seen - tx0, 1);
        check("t4_state",    {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});

        // 5: STOP after four data bits
        rx0 = rx_seen;
        i2c_start();
        send_byte(8'hAA, ack);
        check("t5_addr_ack", {31'd0, ack}, 32'd1);
        clock_bit(1'b1, r); clock_bit(1'b0, r); clock_bit(1'b1, r); clock_bit(1'b1, r);
        i2c_stop();
        wait_q();
        check("t5_rx_count", rx_seen - rx0, 0);
        check("t5_rx_data",  {24'd0, bus.rx_data_o}, 32'h12);
        check("t5_oe",       {31'd0, bus.sda_oe_o}, 32'd0);
        check("t5_state",    {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
        check("t5_busy",     {31'd0, bus.busy_o}, 32'd0);

        // 6: reset while the address ACK is being driven
        i2c_start();
        d = 8'hAA;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        check("t6_ack_driven", {31'd0, bus.sda_oe_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_oe_rst",    {31'd0, bus.sda_oe_o}, 32'd0);
        check("t6_busy_rst",  {31'd0, bus.busy_o},   32'd0);
        check("t6_rxd_rst",   {24'd0, bus.rx_data_o}, 32'd0);
        check("t6_state_rst", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
        rst = 1'b0;
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        rx0 = rx_seen;
        i2c_start();
        send_byte(8'hAA, ack);
        check("t6_addr_ack", {31'd0, ack}, 32'd1);
        host_write(8'h5A, 1'b1, "t6_data_ack");
        i2c_stop();
        wait_q();
        check("t6_rx_count", rx_seen - rx0, 1);
        check("t6_rx_data",  {24'd0, bus.rx_data_o}, 32'h5A);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_core.md
Name: i2c_slave_core

Overview:
Synthesizable I2C target that sits directly downstream of i2c_master_top on the shared sda/scl bus. It replaces the behavioural slave model in the master bench.
- Oversamples SCL/SDA on the I2C core clock.
- Detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs it.
- Write transfers: deserialises bytes to a byte-valid strobe.
- Read transfers: serialises bytes supplied by local logic.
- No clock stretching. SDA is driven open-drain through an output-enable.

Parameters:
SLAVE_ADDR, 7'h55, 7-bit bus address this target responds to.
SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (minimum 2).

Ports:
i2c_core_clock_i  in  1  core clock; all logic is on its rising edge.
core_reset_i  in  1  synchronous, active-high reset.
scl_i  in  1  bus SCL (resolved wire value).
sda_i  in  1  bus SDA (resolved wire value).
sda_oe_o  out  1  1 = pull SDA low; 0 = release (high-Z, pulled up externally).
rx_data_o  out  8  last received write byte.
rx_valid_o  out  1  one-cycle pulse when rx_data_o is updated.
tx_data_i  in  8  byte to return on a read; sampled at tx_req_o.
tx_req_o  out  1  one-cycle pulse; tx_data_i is latched in the same cycle.
busy_o  out  1  1 from address match until STOP, repeated START or NACK.
rw_o  out  1  R/W bit of the current matched transfer (1 = read).

Behaviour:
- Reset: sda_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_req_o=0, busy_o=0, rw_o=0, state=IDLE, synchronisers=1.
- Synchronisation: scl_s and sda_s are taken after SYNC_STAGES flops; the previous sample is kept for edge detection.
- Edge events:
  - scl_rise / scl_fall: scl_s edges.
  - START: sda_s 1->0 while scl_s=1 on both samples.
  - STOP: sda_s 0->1 while scl_s=1 on both samples.
- START or STOP, in any state, takes priority over bit processing in the same cycle.
- START/repeated START: state=ADDR, bit counter=0, sda_oe_o=0, busy_o=0.
- STOP: state=IDLE, sda_oe_o=0, busy_o=0.
- Bit sampling and driving:
  - Data is sampled on scl_rise, MSB first, into an 8-bit shift register.
  - sda_oe_o changes only on scl_fall, except that START, STOP and reset clear it immediately.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits. On the scl_fall after bit 8:
    - match (shift[7:1]==SLAVE_ADDR): sda_oe_o=1 (ACK), rw_o=shift[0], busy_o=1, go to ADDR_ACK.
    - mismatch: go to IDLE with sda_oe_o=0.
  - ADDR_ACK: on the next scl_fall (end of 9th clock):
    - rw_o=0: sda_oe_o=0, go to RX.
    - rw_o=1: pulse tx_req_o, latch tx_data_i, sda_oe_o=~tx_data_i[7], go to TX.
  - RX: shift 8 bits. On the scl_fall after bit 8: rx_data_o=shift, rx_valid_o pulse (1 cycle), sda_oe_o=1, go to RX_ACK.
  - RX_ACK: on scl_fall: sda_oe_o=0, counter=0, go to RX. The target always ACKs write data.
  - TX: on each scl_fall, drive the next bit as sda_oe_o=~bit. After the 8th bit's scl_fall: sda_oe_o=0 (release for the master ACK), go to TX_ACK.
  - TX_ACK: sample SDA on scl_rise.
    - 0 (master ACK): on scl_fall pulse tx_req_o, latch new byte, drive its MSB, go to TX.
    - 1 (NACK): go to IDLE with busy_o=0 and sda_oe_o=0.
- Bit counter: 0..7 wraps per byte and resets on every START.
- Boundary cases:
  - STOP or START mid-byte: the partial byte is discarded and there is no rx_valid_o.
  - Reset mid-transfer releases SDA in the next cycle.
  - rx_valid_o and tx_req_o are never asserted in the same cycle.
  - scl_i held high or low indefinitely: state holds.
- Latency: events are seen SYNC_STAGES+1 core cycles after the bus edge. The master must hold SCL low for at least SYNC_STAGES+2 core cycles.

Test Plan:
1. Write: START, 0xAA (addr 0x55, W), data 0xAA, STOP -> ACK low on the 9th clock of both bytes; rx_valid_o pulses once with rx_data_o=0xAA; busy_o returns to 0 after STOP.
2. Mismatch: START, 0xA8 (addr 0x54) -> sda_oe_o stays 0 for the whole frame; no rx_valid_o; state=IDLE.
3. Read: START, 0xAB, tx_data_i=0x3C, master ACKs byte 1 then NACKs byte 2 with tx_data_i=0xF0 -> SDA bits 0,0,1,1,1,1,0,0 then 1,1,1,1,0,0,0,0; exactly two tx_req_o pulses; IDLE after NACK.
4. Repeated START: write 0xAA with data 0x12, then Sr, 0xAB, read one byte, NACK, STOP -> rx_data_o=0x12; rw_o goes 0 then 1; exactly one tx_req_o.
5. Abort: STOP after 4 data bits of a write -> no rx_valid_o; rx_data_o keeps its previous value; sda_oe_o=0; state=IDLE.
6. Reset: assert core_reset_i while sda_oe_o=1 during an ACK -> sda_oe_o=0 on the next clock; all outputs return to reset values; the next START is decoded normally.
